// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle for univ_shift_reg (master drives en/mode/d/sin, slave returns q/qn/sout/cnt/done)
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             done;
  modport master (output en, mode, d, sin, input q, qn, sout, cnt, done);
  modport slave (input en, mode, d, sin, output q, qn, sout, cnt, done);
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold/load/shl/shr/rol/ror/asr/clr) with serial out and saturating shift counter; ports clk, rst (async, active-high), bus (slave)
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] q, q_nx;
  logic             sout, sout_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             done;
  logic             shift;
  logic             zero;
  always_comb begin
    q_nx    = q;
    sout_nx = sout;
    case (bus.mode)
      3'd1:    q_nx = bus.d;
      3'd2:    {sout_nx, q_nx} = {q, bus.sin};
      3'd3:    {q_nx, sout_nx} = {bus.sin, q};
      3'd4:    {sout_nx, q_nx} = {q, q[WIDTH-1]};
      3'd5:    {q_nx, sout_nx} = {q[0], q};
      3'd6:    {q_nx, sout_nx} = {q[WIDTH-1], q};
      3'd7:    {sout_nx, q_nx} = '0;
      default: ;
    endcase
  end
  assign shift  = bus.mode inside {[3'd2:3'd6]};
  assign zero   = bus.mode == 3'd1 || bus.mode == 3'd7;
  assign cnt_nx = zero ? '0 : (shift && cnt != CW'(WIDTH)) ? cnt + 1'b1 : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q    <= RESET_VAL;
      sout <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (bus.en) begin
      q    <= q_nx;
      sout <= sout_nx;
      cnt  <= cnt_nx;
      done <= cnt_nx == CW'(WIDTH);
    end
  assign bus.q    = q;
  assign bus.qn   = ~q;
  assign bus.sout = sout;
  assign bus.cnt  = cnt;
  assign bus.done = done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0)
module tb_univ_shift_reg;
  typedef struct packed {
    logic [7:0] q;
    logic       sout;
    logic [3:0] cnt;
    logic       done;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  exp_t sb[$];
  logic [7:0] mq = 8'h00;
  logic       ms = 1'b0;
  logic [3:0] mc = 4'd0;
  univ_shift_reg_if #(.WIDTH(8)) bus ();
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.q !== e.q || bus.qn !== ~e.q || bus.sout !== e.sout || bus.cnt !== e.cnt || bus.done !== e.done) begin
        errs++;
        $display("FAIL scoreboard t=%0t: got q=%h qn=%h sout=%b cnt=%0d done=%b, want q=%h qn=%h sout=%b cnt=%0d done=%b",
                 $time, bus.q, bus.qn, bus.sout, bus.cnt, bus.done, e.q, ~e.q, e.sout, e.cnt, e.done);
      end
    end
  end
  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic s);
    @(negedge clk);
    bus.en = e;
    bus.mode = m;
    bus.d = dd;
    bus.sin = s;
    if (e) begin
      case (m)
        3'd1: begin mq = dd; mc = 4'd0; end
        3'd2: begin ms = mq[7]; mq = {mq[6:0], s}; end
        3'd3: begin ms = mq[0]; mq = {s, mq[7:1]}; end
        3'd4: begin ms = mq[7]; mq = {mq[6:0], mq[7]}; end
        3'd5: begin ms = mq[0]; mq = {mq[0], mq[7:1]}; end
        3'd6: begin ms = mq[0]; mq = {mq[7], mq[7:1]}; end
        3'd7: begin mq = 8'h00; ms = 1'b0; mc = 4'd0; end
        default: ;
      endcase
      if (m >= 3'd2 && m <= 3'd6 && mc < 4'd8) mc = mc + 4'd1;
    end
    sb.push_back('{q: mq, sout: ms, cnt: mc, done: mc == 4'd8});
    @(posedge clk);
    #2;
  endtask
  task automatic model_reset();
    mq = 8'h00;
    ms = 1'b0;
    mc = 4'd0;
  endtask
  task automatic test_reset();
    bus.en = 1'b1;
    bus.mode = 3'd0;
    bus.d = 8'h00;
    bus.sin = 1'b0;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.qn !== 8'hFF || bus.sout !== 1'b0 || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: got q=%h qn=%h sout=%b cnt=%0d done=%b, want 00 FF 0 0 0", bus.q, bus.qn, bus.sout, bus.cnt, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'd0, 8'h00, 1'b0);
    checks++;
    if (bus.q !== 8'h00 || bus.qn !== 8'hFF || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL reset_hold: got q=%h qn=%h cnt=%0d done=%b, want 00 FF 0 0", bus.q, bus.qn, bus.cnt, bus.done);
    end
    step(1'b1, 3'd1, 8'h3C, 1'b0);
    checks++;
    if (bus.q !== 8'h3C) begin
      errs++;
      $display("FAIL load_3c: got q=%h, want 3c", bus.q);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.qn !== 8'hFF) begin
      errs++;
      $display("FAIL reset_pulse: got q=%h qn=%h, want 00 FF", bus.q, bus.qn);
    end
    #3 rst = 1'b0;
    model_reset();
  endtask
  task automatic test_shl();
    step(1'b1, 3'd1, 8'hA5, 1'b0);
    step(1'b1, 3'd2, 8'h00, 1'b1);
    checks++;
    if (bus.q !== 8'h4B || bus.qn !== 8'hB4 || bus.sout !== 1'b1 || bus.cnt !== 4'd1) begin
      errs++;
      $display("FAIL shl: got q=%h qn=%h sout=%b cnt=%0d, want 4b b4 1 1", bus.q, bus.qn, bus.sout, bus.cnt);
    end
  endtask
  task automatic test_rotate();
    step(1'b1, 3'd1, 8'h81, 1'b0);
    step(1'b1, 3'd5, 8'h00, 1'b0);
    checks++;
    if (bus.q !== 8'hC0 || bus.sout !== 1'b1) begin
      errs++;
      $display("FAIL ror: got q=%h sout=%b, want c0 1", bus.q, bus.sout);
    end
    step(1'b1, 3'd1, 8'h81, 1'b0);
    step(1'b1, 3'd4, 8'h00, 1'b0);
    checks++;
    if (bus.q !== 8'h03 || bus.sout !== 1'b1 || bus.cnt !== 4'd1) begin
      errs++;
      $display("FAIL rol: got q=%h sout=%b cnt=%0d, want 03 1 1", bus.q, bus.sout, bus.cnt);
    end
  endtask
  task automatic test_asr();
    step(1'b1, 3'd1, 8'h90, 1'b0);
    step(1'b1, 3'd6, 8'h00, 1'b1);
    checks++;
    if (bus.q !== 8'hC8 || bus.sout !== 1'b0) begin
      errs++;
      $display("FAIL asr1: got q=%h sout=%b, want c8 0", bus.q, bus.sout);
    end
    step(1'b1, 3'd6, 8'h00, 1'b1);
    checks++;
    if (bus.q !== 8'hE4 || bus.sout !== 1'b0 || bus.cnt !== 4'd2) begin
      errs++;
      $display("FAIL asr2: got q=%h sout=%b cnt=%0d, want e4 0 2", bus.q, bus.sout, bus.cnt);
    end
  endtask
  task automatic test_saturate();
    step(1'b1, 3'd1, 8'h01, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 3'd3, 8'h00, 1'b0);
      if (i == 1) begin
        checks++;
        if (bus.sout !== 1'b1) begin
          errs++;
          $display("FAIL shr_first_sout: got %b, want 1", bus.sout);
        end
      end
      if (i == 7) begin
        checks++;
        if (bus.cnt !== 4'd7 || bus.done !== 1'b0) begin
          errs++;
          $display("FAIL shr_7: got cnt=%0d done=%b, want 7 0", bus.cnt, bus.done);
        end
      end
      if (i >= 8) begin
        checks++;
        if (bus.q !== 8'h00 || bus.cnt !== 4'd8 || bus.done !== 1'b1) begin
          errs++;
          $display("FAIL shr_sat_%0d: got q=%h cnt=%0d done=%b, want 00 8 1", i, bus.q, bus.cnt, bus.done);
        end
      end
    end
    step(1'b1, 3'd1, 8'hFF, 1'b0);
    checks++;
    if (bus.q !== 8'hFF || bus.cnt !== 4'd0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL load_after_sat: got q=%h cnt=%0d done=%b, want ff 0 0", bus.q, bus.cnt, bus.done);
    end
  endtask
  task automatic test_enable_clr();
    step(1'b1, 3'd1, 8'hB4, 1'b0);
    step(1'b1, 3'd5, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd1, 8'h11, 1'b1);
    checks++;
    if (bus.q !== 8'h5A || bus.cnt !== 4'd1) begin
      errs++;
      $display("FAIL en_low: got q=%h cnt=%0d, want 5a 1", bus.q, bus.cnt);
    end
    step(1'b1, 3'd3, 8'h00, 1'b1);
    step(1'b1, 3'd7, 8'h00, 1'b0);
    checks++;
    if (bus.q !== 8'h00 || bus.qn !== 8'hFF || bus.cnt !== 4'd0 || bus.sout !== 1'b0) begin
      errs++;
      $display("FAIL clr: got q=%h qn=%h cnt=%0d sout=%b, want 00 ff 0 0", bus.q, bus.qn, bus.cnt, bus.sout);
    end
  endtask
  task automatic test_reset_mid();
    step(1'b1, 3'd1, 8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 8'h00, 1'b1);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    checks++;
    if (bus.q !== 8'h00 || bus.cnt !== 4'd0 || bus.sout !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: got q=%h cnt=%0d sout=%b, want 00 0 0", bus.q, bus.cnt, bus.sout);
    end
    step(1'b1, 3'd4, 8'h00, 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
  endtask
  initial begin
    test_reset();
    test_shl();
    test_rotate();
    test_asr();
    test_saturate();
    test_enable_clr();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
